// File: rtl/snoopy_cpu_controller.sv
// CPU-side sequencer for one snoopy cache: turns a CPU read/write into the
// bus transaction (write-back, fetch or invalidate) the coherence protocol asks for.
module snoopy_cpu_controller #(
  parameter int STATE_WIDTH  = 2,
  parameter int WORDS        = 4,
  parameter int OFFSET_WIDTH = $clog2(WORDS)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    cpuRead,
  input  logic                    cpuWrite,
  input  logic                    cpuHit,
  input  logic [STATE_WIDTH-1:0]  lineState,
  output logic                    cpuDone,
  output logic                    protocolCpuRead,
  output logic                    protocolCpuWrite,
  output logic [STATE_WIDTH-1:0]  protocolCpuStateOut,
  input  logic [STATE_WIDTH-1:0]  protocolCpuStateIn,
  input  logic                    writeBackRequired,
  input  logic                    invalidateRequired,
  output logic                    stateWriteEnable,
  output logic [STATE_WIDTH-1:0]  stateWriteData,
  output logic                    dataWriteEnable,
  output logic [OFFSET_WIDTH-1:0] wordOffset,
  output logic                    busRequest,
  input  logic                    busGrant,
  output logic [2:0]              busCommand,
  input  logic                    busAck
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_GRANT,
    WRITE_BACK,
    FETCH,
    INVALIDATE,
    UPDATE
  } ctrlState_t;

  localparam logic [2:0] CMD_NONE       = 3'd0;
  localparam logic [2:0] CMD_READ       = 3'd1;
  localparam logic [2:0] CMD_READ_EXCL  = 3'd2;
  localparam logic [2:0] CMD_INVALIDATE = 3'd3;
  localparam logic [2:0] CMD_WRITE_BACK = 3'd4;

  localparam logic [OFFSET_WIDTH-1:0] LAST_BEAT = OFFSET_WIDTH'(WORDS - 1);

  ctrlState_t              state;
  logic [OFFSET_WIDTH-1:0] beatCount;
  logic                    isWrite;
  logic                    isMiss;
  logic                    needWriteBack;
  logic [STATE_WIDTH-1:0]  nextState;
  logic                    requestPresent;

  assign requestPresent      = cpuRead | cpuWrite;
  assign protocolCpuRead     = (state == IDLE) & cpuRead;
  assign protocolCpuWrite    = (state == IDLE) & cpuWrite;
  assign protocolCpuStateOut = ((state == IDLE) && cpuHit) ? lineState : '0;
  assign dataWriteEnable     = (state == FETCH) & busAck;
  assign wordOffset          = beatCount;

  // Bus-facing and commit outputs are registered: each is set on the edge
  // that enters the state it belongs to, so they never glitch with inputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      beatCount        <= '0;
      isWrite          <= 1'b0;
      isMiss           <= 1'b0;
      needWriteBack    <= 1'b0;
      nextState        <= '0;
      busRequest       <= 1'b0;
      busCommand       <= CMD_NONE;
      stateWriteEnable <= 1'b0;
      stateWriteData   <= '0;
      cpuDone          <= 1'b0;
    end else begin
      stateWriteEnable <= 1'b0;
      stateWriteData   <= '0;
      cpuDone          <= 1'b0;
      case (state)
        IDLE: begin
          if (requestPresent) begin
            isWrite       <= cpuWrite;
            isMiss        <= ~cpuHit;
            needWriteBack <= ~cpuHit & writeBackRequired;
            nextState     <= protocolCpuStateIn;
            if (cpuHit && !invalidateRequired) begin
              state            <= UPDATE;
              stateWriteEnable <= 1'b1;
              stateWriteData   <= protocolCpuStateIn;
              cpuDone          <= 1'b1;
            end else begin
              state      <= WAIT_GRANT;
              busRequest <= 1'b1;
            end
          end
        end
        WAIT_GRANT: begin
          if (busGrant) begin
            if (needWriteBack) begin
              state      <= WRITE_BACK;
              busCommand <= CMD_WRITE_BACK;
            end else if (isMiss) begin
              state      <= FETCH;
              busCommand <= isWrite ? CMD_READ_EXCL : CMD_READ;
            end else begin
              state      <= INVALIDATE;
              busCommand <= CMD_INVALIDATE;
            end
          end
        end
        WRITE_BACK: begin
          if (busAck) begin
            if (beatCount == LAST_BEAT) begin
              beatCount  <= '0;
              state      <= FETCH;
              busCommand <= isWrite ? CMD_READ_EXCL : CMD_READ;
            end else begin
              beatCount <= beatCount + 1'b1;
            end
          end
        end
        FETCH: begin
          if (busAck) begin
            if (beatCount == LAST_BEAT) begin
              beatCount        <= '0;
              state            <= UPDATE;
              busCommand       <= CMD_NONE;
              busRequest       <= 1'b0;
              stateWriteEnable <= 1'b1;
              stateWriteData   <= nextState;
              cpuDone          <= 1'b1;
            end else begin
              beatCount <= beatCount + 1'b1;
            end
          end
        end
        INVALIDATE: begin
          if (busAck) begin
            state            <= UPDATE;
            busCommand       <= CMD_NONE;
            busRequest       <= 1'b0;
            stateWriteEnable <= 1'b1;
            stateWriteData   <= nextState;
            cpuDone          <= 1'b1;
          end
        end
        UPDATE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_snoopy_cpu_controller.sv
// Directed bench for snoopy_cpu_controller: a transaction-level model predicts
// every output each cycle, and literal expectations pin latency and pulse counts.
module tb_snoopy_cpu_controller;

  localparam int SW    = 2;
  localparam int WORDS = 4;
  localparam int OW    = 2;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          cpuRead = 1'b0, cpuWrite = 1'b0, cpuHit = 1'b0;
  logic [SW-1:0] lineState = '0, protocolCpuStateIn = '0;
  logic          writeBackRequired = 1'b0, invalidateRequired = 1'b0;
  logic          busGrant = 1'b0, busAck = 1'b0;
  logic          cpuDone, protocolCpuRead, protocolCpuWrite;
  logic [SW-1:0] protocolCpuStateOut, stateWriteData;
  logic          stateWriteEnable, dataWriteEnable, busRequest;
  logic [OW-1:0] wordOffset;
  logic [2:0]    busCommand;

  always #5 clock = ~clock;

  snoopy_cpu_controller #(.STATE_WIDTH(SW), .WORDS(WORDS)) dut (
    .clock(clock), .reset(reset),
    .cpuRead(cpuRead), .cpuWrite(cpuWrite), .cpuHit(cpuHit), .lineState(lineState),
    .cpuDone(cpuDone),
    .protocolCpuRead(protocolCpuRead), .protocolCpuWrite(protocolCpuWrite),
    .protocolCpuStateOut(protocolCpuStateOut), .protocolCpuStateIn(protocolCpuStateIn),
    .writeBackRequired(writeBackRequired), .invalidateRequired(invalidateRequired),
    .stateWriteEnable(stateWriteEnable), .stateWriteData(stateWriteData),
    .dataWriteEnable(dataWriteEnable), .wordOffset(wordOffset),
    .busRequest(busRequest), .busGrant(busGrant), .busCommand(busCommand), .busAck(busAck)
  );

  int checks = 0;
  int errors = 0;

  int dwePulses = 0, donePulses = 0, swePulses = 0, ackedBeats = 0;
  int lastCommit = -1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // The model sees a request as a phase plus a queue of planned bus beats.
  typedef struct { int cmd; int off; } beat_t;
  typedef enum { M_IDLE, M_WAIT, M_BURST, M_COMMIT } mPhase_t;
  beat_t   plan[$];
  mPhase_t mPhase = M_IDLE;
  int      mNext  = 0;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      mPhase = M_IDLE;
      plan.delete();
      mNext = 0;
    end else begin
      case (mPhase)
        M_IDLE: if (cpuRead || cpuWrite) begin
          mNext = int'(protocolCpuStateIn);
          if (cpuHit && !invalidateRequired) mPhase = M_COMMIT;
          else begin
            if (!cpuHit && writeBackRequired)
              for (int i = 0; i < WORDS; i++) plan.push_back('{cmd: 4, off: i});
            if (!cpuHit)
              for (int i = 0; i < WORDS; i++) plan.push_back('{cmd: (cpuWrite ? 2 : 1), off: i});
            else
              plan.push_back('{cmd: 3, off: 0});
            mPhase = M_WAIT;
          end
        end
        M_WAIT:   if (busGrant) mPhase = M_BURST;
        M_BURST:  if (busAck) begin
          void'(plan.pop_front());
          if (plan.size() == 0) mPhase = M_COMMIT;
        end
        M_COMMIT: mPhase = M_IDLE;
        default:  mPhase = M_IDLE;
      endcase
    end
  end

  always @(negedge clock) begin
    bit idle, burst, commit;
    int eCmd, eOff, eDwe;
    idle   = (mPhase == M_IDLE);
    burst  = (mPhase == M_BURST);
    commit = (mPhase == M_COMMIT);
    eCmd   = burst ? plan[0].cmd : 0;
    eOff   = burst ? plan[0].off : 0;
    eDwe   = (burst && (eCmd == 1 || eCmd == 2) && busAck) ? 1 : 0;
    checkOutput("protocolCpuRead", int'(protocolCpuRead), idle ? int'(cpuRead) : 0);
    checkOutput("protocolCpuWrite", int'(protocolCpuWrite), idle ? int'(cpuWrite) : 0);
    checkOutput("protocolCpuStateOut", int'(protocolCpuStateOut), (idle && cpuHit) ? int'(lineState) : 0);
    checkOutput("busRequest", int'(busRequest), (mPhase == M_WAIT || burst) ? 1 : 0);
    checkOutput("busCommand", int'(busCommand), eCmd);
    checkOutput("wordOffset", int'(wordOffset), eOff);
    checkOutput("dataWriteEnable", int'(dataWriteEnable), eDwe);
    checkOutput("stateWriteEnable", int'(stateWriteEnable), commit ? 1 : 0);
    checkOutput("stateWriteData", int'(stateWriteData), commit ? mNext : 0);
    checkOutput("cpuDone", int'(cpuDone), commit ? 1 : 0);
    if (dataWriteEnable) dwePulses++;
    if (cpuDone) donePulses++;
    if (stateWriteEnable) begin swePulses++; lastCommit = int'(stateWriteData); end
    if (busAck && busCommand != 3'd0) ackedBeats++;
  end

  task automatic applyStimulus(input bit rd, input bit wr, input bit hit, input int ls,
                               input int pin, input bit wb, input bit inv);
    cpuRead = rd; cpuWrite = wr; cpuHit = hit;
    lineState = SW'(ls); protocolCpuStateIn = SW'(pin);
    writeBackRequired = wb; invalidateRequired = inv;
    dwePulses = 0; donePulses = 0; swePulses = 0; ackedBeats = 0; lastCommit = -1;
  endtask

  task automatic dropInputs();
    cpuRead = 0; cpuWrite = 0; cpuHit = 0; lineState = '0; protocolCpuStateIn = '0;
    writeBackRequired = 0; invalidateRequired = 0; busGrant = 0; busAck = 0;
  endtask

  // Plays arbiter and memory until cpuDone; optionally asserts reset at a write-back beat.
  task automatic runTransaction(input int grantDelay, input bit altAck, input int resetAtWbBeat,
                                output int latency);
    int waitCnt;
    bit done;
    waitCnt = 0; done = 0; latency = -1;
    for (int cyc = 1; cyc <= 60 && !done; cyc++) begin
      @(posedge clock); #2;
      if (resetAtWbBeat >= 0 && busCommand == 3'd4 && int'(wordOffset) == resetAtWbBeat) begin
        reset = 1'b1;
        dropInputs();
        latency = cyc;
        done = 1;
      end else begin
        if (cpuDone) begin latency = cyc; done = 1; end
        if (busRequest) waitCnt++;
        busGrant = busRequest && (waitCnt > grantDelay);
        busAck   = busGrant && (!altAck || (cyc % 2 == 1));
      end
    end
    checkOutput("transactionCompletes", int'(done), 1);
    if (resetAtWbBeat < 0) begin
      @(posedge clock); #2;
      dropInputs();
    end
  endtask

  int lat;

  initial begin
    #2;
    @(posedge clock); @(posedge clock); #2;
    checkOutput("resetBusRequest", int'(busRequest), 0);
    checkOutput("resetCpuDone", int'(cpuDone), 0);
    reset = 1'b0;
    @(posedge clock); #2;

    $display("[TB] read hit");
    applyStimulus(1, 0, 1, 1, 1, 0, 0);
    runTransaction(0, 0, -1, lat);
    checkOutput("hitLatency", lat, 1);
    checkOutput("hitCommit", lastCommit, 1);
    checkOutput("hitDataWrites", dwePulses, 0);

    $display("[TB] clean read miss, grant after two waits");
    applyStimulus(1, 0, 0, 0, 1, 0, 0);
    runTransaction(2, 0, -1, lat);
    checkOutput("cleanMissLatency", lat, 2 + 2 + WORDS);
    checkOutput("cleanMissDataWrites", dwePulses, WORDS);
    checkOutput("cleanMissDone", donePulses, 1);
    checkOutput("cleanMissCommit", lastCommit, 1);

    $display("[TB] dirty write miss");
    applyStimulus(0, 1, 0, 3, 2, 1, 0);
    runTransaction(1, 0, -1, lat);
    checkOutput("dirtyMissLatency", lat, 1 + 1 + 2 * WORDS + 1);
    checkOutput("dirtyMissBeats", ackedBeats, 2 * WORDS);
    checkOutput("dirtyMissDataWrites", dwePulses, WORDS);
    checkOutput("dirtyMissCommit", lastCommit, 2);

    $display("[TB] write hit with invalidate");
    applyStimulus(0, 1, 1, 1, 2, 0, 1);
    runTransaction(0, 0, -1, lat);
    checkOutput("invalidateLatency", lat, 3);
    checkOutput("invalidateBeats", ackedBeats, 1);
    checkOutput("invalidateDataWrites", dwePulses, 0);
    checkOutput("invalidateCommit", lastCommit, 2);

    $display("[TB] read miss with alternating acks");
    applyStimulus(1, 0, 0, 0, 3, 0, 0);
    runTransaction(0, 1, -1, lat);
    checkOutput("stallDataWrites", dwePulses, WORDS);
    checkOutput("stallDone", donePulses, 1);
    checkOutput("stallCommit", lastCommit, 3);

    $display("[TB] reset during write-back beat 2");
    applyStimulus(0, 1, 0, 2, 2, 1, 0);
    runTransaction(0, 0, 2, lat);
    #1;
    checkOutput("midResetBusRequest", int'(busRequest), 0);
    checkOutput("midResetBusCommand", int'(busCommand), 0);
    checkOutput("midResetWordOffset", int'(wordOffset), 0);
    checkOutput("midResetCpuDone", int'(cpuDone), 0);
    @(posedge clock); #2;
    reset = 1'b0;
    @(posedge clock); #2;
    checkOutput("midResetNoCommit", swePulses, 0);
    checkOutput("midResetNoDone", donePulses, 0);

    $display("[TB] read hit after reset");
    applyStimulus(1, 0, 1, 2, 2, 0, 0);
    runTransaction(0, 0, -1, lat);
    checkOutput("postResetHitLatency", lat, 1);
    checkOutput("postResetHitCommit", lastCommit, 2);

    repeat (2) @(posedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
